// File: rtl/instr_qword_fetcher.sv
// Memory-side responder for I-cache line refills: one 128-bit qword per 4-phase
// req/ack handshake, assembled from four sequential 32-bit memory reads.
module instr_qword_fetcher #(
  parameter int BUS_ADDRESS_WIDTH = 20
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [BUS_ADDRESS_WIDTH-5:0] bus_addr_i,
  input  logic                         bus_valid_i,
  output logic [127:0]                 bus_data_o,
  output logic                         bus_valid_o,
  output logic [BUS_ADDRESS_WIDTH-3:0] mem_addr_o,
  output logic                         mem_rd_o,
  input  logic                         mem_ready_i,
  input  logic [31:0]                  mem_data_i,
  input  logic                         mem_valid_i,
  output logic                         busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACK,
    S_DROP
  } state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic [BUS_ADDRESS_WIDTH-5:0] r_addr;
  logic [1:0]                   r_cnt;
  logic [127:0]                 r_data;
  logic                         w_latch;
  logic                         w_capture;

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus_valid_i) begin
          w_next  = S_REQ;
          w_latch = 1'b1;
        end
      end
      S_REQ: begin
        if (mem_ready_i) w_next = S_WAIT;
      end
      S_WAIT: begin
        // Responses are only honoured here, so strays in other states drop out.
        if (mem_valid_i) begin
          w_capture = 1'b1;
          w_next    = (r_cnt == 2'd3) ? S_ACK : S_REQ;
        end
      end
      S_ACK: begin
        if (!bus_valid_i) w_next = S_DROP;
      end
      S_DROP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr <= '0;
      r_cnt  <= '0;
      r_data <= '0;
    end else begin
      if (w_latch) begin
        r_addr <= bus_addr_i;
        r_cnt  <= '0;
      end
      if (w_capture) begin
        r_data[{r_cnt, 5'd0} +: 32] <= mem_data_i;
        // Counter parks at 3 after the last lane; the next request clears it.
        if (r_cnt != 2'd3) r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  assign mem_rd_o    = (r_state == S_REQ);
  assign bus_valid_o = (r_state == S_ACK);
  assign busy_o      = (r_state != S_IDLE);
  assign mem_addr_o  = {r_addr, r_cnt};
  assign bus_data_o  = r_data;

endmodule
